// File: rtl/scan_hex_display.sv
// Time-multiplexed hex driver for common-anode 7-segment banks: one digit per SCAN_DIV clocks,
// frame-aligned value updates, leading-zero blanking and per-digit blink.
module scan_hex_display #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_blank_lz,
  input  logic [NUM_DIGITS-1:0]   i_blink_en,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig,
  output logic                    o_frame_done
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PrescW-1:0]     PrescMax = PrescW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]       IdxMax   = IdxW'(NUM_DIGITS - 1);
  localparam logic [FrameW-1:0]     FrameMax = FrameW'(BLINK_FRAMES - 1);
  localparam logic [6:0]            SegOff   = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DigOff   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [PrescW-1:0]       r_presc;
  logic [IdxW-1:0]         r_idx;
  logic [FrameW-1:0]       r_frame_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_upper_zero;
  logic                    w_lz;
  logic                    w_blink;
  logic                    w_blank;
  logic [6:0]              w_seg_d;
  logic [NUM_DIGITS-1:0]   w_dig_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    unique case (nib)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      4'hF: code = 7'b0001110;
    endcase
    return code;
  endfunction

  assign w_tick = (r_presc == PrescMax);
  assign w_wrap = w_tick && (r_idx == IdxMax);

  // Walk from the most significant digit down so w_upper_zero covers digits k..NUM_DIGITS-1.
  always_comb begin
    w_nib        = 4'h0;
    w_lz         = 1'b0;
    w_blink      = 1'b0;
    w_upper_zero = 1'b1;
    w_dig_d      = DigOff;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_upper_zero = w_upper_zero && (r_disp[4*k +: 4] == 4'h0);
      if (IdxW'(k) == r_idx) begin
        w_nib      = r_disp[4*k +: 4];
        w_lz       = w_upper_zero && (k != 0);
        w_blink    = i_blink_en[k];
        w_dig_d[k] = ~DIG_ACTIVE_LOW;
      end
    end
  end

  always_comb begin
    w_blank = (w_blink && r_blink_phase) || (i_blank_lz && w_lz);
    w_seg_d = SEG_ACTIVE_LOW ? hex_to_seg(w_nib) : ~hex_to_seg(w_nib);
    if (w_blank) begin
      w_seg_d = SegOff;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PrescW'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IdxMax) ? '0 : r_idx + IdxW'(1);
      end
      if (w_wrap) begin
        if (r_frame_cnt == FrameMax) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FrameW'(1);
        end
      end
    end
  end

  // A load on the wrap cycle commits the older pending value and re-arms with the new one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp    <= '0;
      r_pend    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_disp <= r_pend;
      end
      if (i_load) begin
        r_pend    <= i_value;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg        <= SegOff;
      r_dig        <= DigOff;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_d;
      r_dig        <= w_dig_d;
      r_frame_done <= w_wrap;
    end
  end

  assign o_seg        = r_seg;
  assign o_dig        = r_dig;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_hex_display.sv
// Randomised scoreboard bench for scan_hex_display; expected outputs come from a cycle-count
// model of slots, frames and a log of loads.
module tb_scan_hex_display;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = SD * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = 4'h0;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  always #5 clk = ~clk;

  scan_hex_display #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .BLINK_FRAMES  (BF),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_value     (value),
    .i_blank_lz  (blank_lz),
    .i_blink_en  (blink_en),
    .o_seg       (seg),
    .o_dig       (dig),
    .o_frame_done(frame_done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sb_active = 1'b0;
  logic [11:0] exp_q[$];
  int          cyc_q[$];
  int          c = 0;
  int          ld_edge[$];
  logic [15:0] ld_val[$];

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Value on screen during the frame containing edge cyc: the last load made strictly
  // before the final edge of the previous frame.
  function automatic logic [15:0] shown(input int cyc);
    int          lim = (cyc / FRAME) * FRAME - 1;
    logic [15:0] r = 16'h0;
    for (int i = 0; i < ld_edge.size(); i++) begin
      if (ld_edge[i] < lim) r = ld_val[i];
    end
    return r;
  endfunction

  function automatic logic [11:0] expect_at(input int cyc);
    int          slot = (cyc / SD) % ND;
    logic [15:0] d = shown(cyc);
    logic [15:0] upper = d >> (4 * slot);
    bit          ph = ((cyc / FRAME) / BF) % 2;
    bit          blanked;
    logic [3:0]  one = 4'b0001;
    logic [6:0]  s;
    logic [3:0]  g;
    bit          fd;
    blanked = (blink_en[slot] && ph) || (blank_lz && slot > 0 && upper == 16'h0);
    s  = blanked ? 7'h7F : seg_code(upper[3:0]);
    g  = ~(one << slot);
    fd = (cyc % FRAME) == FRAME - 1;
    return {s, g, fd};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got seg=%b dig=%b fd=%b, want seg=%b dig=%b fd=%b", name,
               act[11:5], act[4:1], act[0], exp[11:5], exp[4:1], exp[0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check($sformatf("scan@%0d", cyc_q.pop_front()), {seg, dig, frame_done}, exp_q.pop_front());
    end else if (sb_active) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: no expected entry, got seg=%b dig=%b", seg, dig);
    end
  end

  task automatic drive_cycle(input bit ld, input logic [15:0] v);
    load  = ld;
    value = v;
    exp_q.push_back(expect_at(c));
    cyc_q.push_back(c);
    if (ld) begin
      ld_edge.push_back(c);
      ld_val.push_back(v);
    end
    c++;
    @(posedge clk);
    #3;
  endtask

  task automatic run_to(input int ph);
    while (c % FRAME != ph) drive_cycle(1'b0, 16'h0);
  endtask

  task automatic restart_model();
    c = 0;
    ld_edge.delete();
    ld_val.delete();
  endtask

  // Entered 3 time units after a rising edge, i.e. mid-slot.
  task automatic pulse_reset();
    sb_active = 1'b0;
    load      = 1'b0;
    rst       = 1'b1;
    #1;
    check("async_off", {seg, dig, frame_done}, {7'h7F, 4'hF, 1'b0});
    @(posedge clk);
    #1;
    check("reset_held", {seg, dig, frame_done}, {7'h7F, 4'hF, 1'b0});
    #2;
    rst = 1'b0;
    restart_model();
    sb_active = 1'b1;
  endtask

  initial begin
    logic [15:0] mask;
    #2 rst = 1'b1;
    #1 check("reset_async", {seg, dig, frame_done}, {7'h7F, 4'hF, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_hold", {seg, dig, frame_done}, {7'h7F, 4'hF, 1'b0});
    #2 rst = 1'b0;
    restart_model();
    sb_active = 1'b1;

    repeat (40) drive_cycle(1'b0, 16'h0);

    run_to(6);
    drive_cycle(1'b1, 16'h1A3F);
    repeat (2 * FRAME) drive_cycle(1'b0, 16'h0);

    blank_lz = 1'b1;
    drive_cycle(1'b1, 16'h0070);
    repeat (3 * FRAME) drive_cycle(1'b0, 16'h0);
    drive_cycle(1'b1, 16'h0000);
    repeat (3 * FRAME) drive_cycle(1'b0, 16'h0);

    blank_lz = 1'b0;
    blink_en = 4'b0001;
    drive_cycle(1'b1, 16'h8421);
    repeat (6 * FRAME) drive_cycle(1'b0, 16'h0);
    blink_en = 4'b0000;

    run_to(10);
    drive_cycle(1'b1, 16'h1111);
    run_to(FRAME - 1);
    drive_cycle(1'b1, 16'h2222);
    repeat (3 * FRAME) drive_cycle(1'b0, 16'h0);

    run_to(6);
    pulse_reset();
    repeat (2 * FRAME) drive_cycle(1'b0, 16'h0);

    for (int i = 0; i < 800; i++) begin
      if (i % 48 == 0) begin
        blank_lz = 1'($urandom_range(0, 1));
        blink_en = 4'($urandom);
      end
      case ($urandom_range(0, 3))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h00FF;
        2:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      drive_cycle($urandom_range(0, 5) == 0, 16'($urandom) & mask);
      if (i == 500) pulse_reset();
    end

    sb_active = 1'b0;
    load = 1'b0;
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
